// File: rtl/rtc_bus_txn_if.sv
// Sequencer/RTC-side signal bundle for rtc_bus_txn.
// master = sequencer + RTC pins side, slave = the transaction block.
interface rtc_bus_txn_if;
    logic       start;
    logic       rw;
    logic [4:0] addr_idx;
    logic [7:0] wdata;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic [7:0] rdata;
    logic       busy;
    logic       final_wr;
    logic       err;

    modport master (
        output start, rw, addr_idx, wdata, ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, rdata, busy, final_wr, err
    );

    modport slave (
        input  start, rw, addr_idx, wdata, ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, rdata, busy, final_wr, err
    );
endinterface

// File: rtl/rtc_bus_txn.sv
// One multiplexed address/data RTC bus transaction per start, paced by T_PHASE.
// Optional macro RTC_RANGE_CHECK_EN: out-of-range addr_idx pulses err.
module rtc_bus_txn #(
    parameter int unsigned T_PHASE   = 4,
    parameter logic [7:0]  ADDR_BASE = 8'h21
) (
    input  logic         clk,
    input  logic         reset,
    rtc_bus_txn_if.slave bus
);

    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(T_PHASE - 1);
    localparam logic [4:0] IDX_MAX   = 5'd21;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADR_LO,
        S_ADR_HI,
        S_GAP,
        S_DAT_LO,
        S_DAT_HI,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_rw, w_rw_nxt;
    logic [4:0]       r_idx, w_idx_nxt;
    logic [7:0]       r_wdata, w_wdata_nxt;
    logic [7:0]       r_ad_out, w_ad_out_nxt;
    logic             r_ad_oe, w_ad_oe_nxt;
    logic             r_cs_n, w_cs_n_nxt;
    logic             r_rd_n, w_rd_n_nxt;
    logic             r_wr_n, w_wr_n_nxt;
    logic             r_a_d, w_a_d_nxt;
    logic [7:0]       r_rdata, w_rdata_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_final_wr, w_final_wr_nxt;
    logic             r_err, w_err_nxt;

    logic             w_legal;
    logic             w_phase_end;
    logic [7:0]       w_addr;

    assign w_legal     = (bus.addr_idx != 5'd0) && (bus.addr_idx <= IDX_MAX);
    assign w_phase_end = (r_cnt == '0);
    assign w_addr      = 8'(ADDR_BASE + 8'(r_idx) - 8'd1);

    // Next state, phase counter, field latches, and bus outputs decoded from the current state
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rw_nxt       = r_rw;
        w_idx_nxt      = r_idx;
        w_wdata_nxt    = r_wdata;
        w_ad_out_nxt   = r_ad_out;
        w_ad_oe_nxt    = 1'b0;
        w_cs_n_nxt     = 1'b1;
        w_rd_n_nxt     = 1'b1;
        w_wr_n_nxt     = 1'b1;
        w_a_d_nxt      = 1'b0;
        w_rdata_nxt    = r_rdata;
        w_busy_nxt     = (r_state != S_IDLE);
        w_final_wr_nxt = 1'b0;
        w_err_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (bus.start) begin
                    if (w_legal) begin
                        w_state_nxt = S_ADR_LO;
                        w_cnt_nxt   = CNT_LOAD;
                        w_rw_nxt    = bus.rw;
                        w_idx_nxt   = bus.addr_idx;
                        w_wdata_nxt = bus.wdata;
                    end else begin
`ifdef RTC_RANGE_CHECK_EN
                        w_err_nxt = 1'b1;
`endif
                    end
                end
            end
            S_ADR_LO: begin
                w_cs_n_nxt   = 1'b0;
                w_wr_n_nxt   = 1'b0;
                w_ad_oe_nxt  = 1'b1;
                w_ad_out_nxt = w_addr;
                if (w_phase_end) begin
                    w_state_nxt = S_ADR_HI;
                    w_cnt_nxt   = CNT_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_ADR_HI: begin
                w_cs_n_nxt  = 1'b0;
                w_ad_oe_nxt = 1'b1;
                if (w_phase_end) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = CNT_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (w_phase_end) begin
                    w_state_nxt = S_DAT_LO;
                    w_cnt_nxt   = CNT_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DAT_LO: begin
                w_cs_n_nxt = 1'b0;
                w_a_d_nxt  = 1'b1;
                if (r_rw) begin
                    w_rd_n_nxt = 1'b0;
                end else begin
                    w_wr_n_nxt   = 1'b0;
                    w_ad_oe_nxt  = 1'b1;
                    w_ad_out_nxt = r_wdata;
                end
                if (w_phase_end) begin
                    // Read data is taken on the edge that leaves the strobe phase
                    if (r_rw) w_rdata_nxt = bus.ad_in;
                    w_state_nxt = S_DAT_HI;
                    w_cnt_nxt   = CNT_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DAT_HI: begin
                w_cs_n_nxt  = 1'b0;
                w_a_d_nxt   = 1'b1;
                w_ad_oe_nxt = ~r_rw;
                if (w_phase_end) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                w_final_wr_nxt = 1'b1;
                w_state_nxt    = S_IDLE;
                w_cnt_nxt      = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rw       <= 1'b0;
            r_idx      <= 5'd0;
            r_wdata    <= 8'd0;
            r_ad_out   <= 8'd0;
            r_ad_oe    <= 1'b0;
            r_cs_n     <= 1'b1;
            r_rd_n     <= 1'b1;
            r_wr_n     <= 1'b1;
            r_a_d      <= 1'b0;
            r_rdata    <= 8'd0;
            r_busy     <= 1'b0;
            r_final_wr <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rw       <= w_rw_nxt;
            r_idx      <= w_idx_nxt;
            r_wdata    <= w_wdata_nxt;
            r_ad_out   <= w_ad_out_nxt;
            r_ad_oe    <= w_ad_oe_nxt;
            r_cs_n     <= w_cs_n_nxt;
            r_rd_n     <= w_rd_n_nxt;
            r_wr_n     <= w_wr_n_nxt;
            r_a_d      <= w_a_d_nxt;
            r_rdata    <= w_rdata_nxt;
            r_busy     <= w_busy_nxt;
            r_final_wr <= w_final_wr_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.ad_out   = r_ad_out;
    assign bus.ad_oe    = r_ad_oe;
    assign bus.cs_n     = r_cs_n;
    assign bus.rd_n     = r_rd_n;
    assign bus.wr_n     = r_wr_n;
    assign bus.a_d      = r_a_d;
    assign bus.rdata    = r_rdata;
    assign bus.busy     = r_busy;
    assign bus.final_wr = r_final_wr;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_rtc_bus_txn.sv
// Self-checking bench for rtc_bus_txn: transaction-offset reference model plus directed literal checks.
module tb_rtc_bus_txn;

    localparam int unsigned T    = 4;
    localparam int unsigned LAT  = 5 * T + 1;
    localparam logic [7:0]  BASE = 8'h21;
    localparam int          KMAX = 1000;
`ifdef RTC_RANGE_CHECK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rtc_bus_txn_if bus ();

    rtc_bus_txn #(.T_PHASE(T), .ADDR_BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_k = clock edges since the accepting edge (saturates at KMAX)
    int         m_k = KMAX;
    logic       m_rw;
    logic [4:0] m_idx;
    logic [7:0] m_wdata, m_ad_out, m_rdata;
    logic       m_err;
    logic       m_legal, m_acc;
    int         m_nk;

    always_comb begin
        m_legal = (bus.addr_idx >= 5'd1) && (bus.addr_idx <= 5'd21);
        m_acc   = (m_k >= LAT) && bus.start && m_legal;
        m_nk    = m_acc ? 0 : ((m_k < KMAX) ? m_k + 1 : m_k);
    end

    function automatic logic [7:0] addr_of(input logic [4:0] idx);
        logic [7:0] a;
        a = BASE + {3'b000, idx} - 8'd1;
        return a;
    endfunction

    // Phase seen on the outputs at offset k: 0 idle, 1..5 bus phases, 6 done
    function automatic int ph(input int k);
        if (k >= 1 && k <= 5 * T) return (k - 1) / T + 1;
        if (k == 5 * T + 1) return 6;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k      <= KMAX;
            m_ad_out <= 8'd0;
            m_rdata  <= 8'd0;
            m_err    <= 1'b0;
            m_rw     <= 1'b0;
            m_idx    <= 5'd0;
            m_wdata  <= 8'd0;
        end else begin
            m_k   <= m_nk;
            m_err <= RCHK && (m_k >= LAT) && bus.start && !m_legal;
            if (m_acc) begin
                m_rw    <= bus.rw;
                m_idx   <= bus.addr_idx;
                m_wdata <= bus.wdata;
            end
            if (m_nk >= 1 && m_nk <= T) m_ad_out <= addr_of(m_idx);
            if (!m_rw && m_nk >= 3 * T + 1 && m_nk <= 4 * T) m_ad_out <= m_wdata;
            if (m_rw && m_nk == 4 * T) m_rdata <= bus.ad_in;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("cs_n",     8'(bus.cs_n),     8'(!(ph(m_k) inside {1, 2, 4, 5})));
        chk("rd_n",     8'(bus.rd_n),     8'(!(ph(m_k) == 4 && m_rw)));
        chk("wr_n",     8'(bus.wr_n),     8'(!(ph(m_k) == 1 || (ph(m_k) == 4 && !m_rw))));
        chk("ad_oe",    8'(bus.ad_oe),    8'(ph(m_k) == 1 || ph(m_k) == 2 || ((ph(m_k) == 4 || ph(m_k) == 5) && !m_rw)));
        chk("a_d",      8'(bus.a_d),      8'(ph(m_k) == 4 || ph(m_k) == 5));
        chk("busy",     8'(bus.busy),     8'(ph(m_k) != 0));
        chk("final_wr", 8'(bus.final_wr), 8'(ph(m_k) == 6));
        chk("err",      8'(bus.err),      8'(m_err));
        chk("ad_out",   bus.ad_out,       m_ad_out);
        chk("rdata",    bus.rdata,        m_rdata);
        chk("oe_rd_excl", 8'(bus.ad_oe && !bus.rd_n), 8'd0);
    end

    // One transaction with optional start re-pulses; counts strobe windows and final_wr pulses
    task automatic run_txn(input logic rw, input logic [4:0] idx, input logic [7:0] wd,
                           input logic [7:0] rdin, input int rp1, input int rp2,
                           output int n_aw, output int n_dw, output int n_rd,
                           output int n_oe_dat, output int fin_at, output int n_fin);
        n_aw = 0; n_dw = 0; n_rd = 0; n_oe_dat = 0; fin_at = -1; n_fin = 0;
        bus.start    = 1'b1;
        bus.rw       = rw;
        bus.addr_idx = idx;
        bus.wdata    = wd;
        bus.ad_in    = rdin;
        for (int j = 0; j <= LAT + 6; j++) begin
            @(negedge clk);
            if (j == rp1 || j == rp2) begin
                bus.start    = 1'b1;
                bus.rw       = ~rw;
                bus.addr_idx = 5'd7;
                bus.wdata    = ~wd;
            end else begin
                bus.start = 1'b0;
            end
            if (!bus.wr_n && !bus.a_d && bus.ad_out == addr_of(idx)) n_aw++;
            if (!bus.wr_n &&  bus.a_d && bus.ad_out == wd) n_dw++;
            if (!bus.rd_n) n_rd++;
            if (bus.a_d && bus.ad_oe) n_oe_dat++;
            if (bus.final_wr) begin
                n_fin++;
                if (fin_at < 0) fin_at = j;
            end
        end
    endtask

    int         aw, dw, rd, oed, fat, nf;
    int         pulses, busy_hi;
    logic [7:0] seen_addr[$];
    logic       mon_en = 1'b0;
    logic       prev_cs_n = 1'b1;
    logic [7:0] want_a;

    // Address-phase monitor for the sequencer run
    always @(negedge clk) begin
        if (mon_en && prev_cs_n && !bus.cs_n && !bus.a_d) seen_addr.push_back(bus.ad_out);
        prev_cs_n <= bus.cs_n;
    end

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.rw       = 1'b0;
        bus.addr_idx = 5'd0;
        bus.wdata    = 8'd0;
        bus.ad_in    = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n",  8'(bus.cs_n),  8'd1);
        chk("rst_busy",  8'(bus.busy),  8'd0);
        chk("rst_rdata", bus.rdata,     8'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Write idx 1, 0x5A
        run_txn(1'b0, 5'd1, 8'h5A, 8'h00, -1, -1, aw, dw, rd, oed, fat, nf);
        chk("wr_addr_cycles", 8'(aw), 8'd4);
        chk("wr_data_cycles", 8'(dw), 8'd4);
        chk("wr_final_at",    8'(fat), 8'd21);
        chk("wr_final_cnt",   8'(nf), 8'd1);

        // Read idx 21 returning 0xC3
        run_txn(1'b1, 5'd21, 8'h00, 8'hC3, -1, -1, aw, dw, rd, oed, fat, nf);
        chk("rd_rd_cycles",  8'(rd), 8'd4);
        chk("rd_oe_data",    8'(oed), 8'd0);
        chk("rd_rdata",      bus.rdata, 8'hC3);
        chk("rd_final_at",   8'(fat), 8'd21);
        chk("addr_idx21",    addr_of(5'd21), 8'h35);

        // Re-pulsed start mid-transaction
        run_txn(1'b0, 5'd3, 8'hA7, 8'h00, 3, 10, aw, dw, rd, oed, fat, nf);
        chk("rp_final_cnt",   8'(nf), 8'd1);
        chk("rp_final_at",    8'(fat), 8'd21);
        chk("rp_addr_cycles", 8'(aw), 8'd4);
        chk("rp_data_cycles", 8'(dw), 8'd4);
        chk("rp_rdata_kept",  bus.rdata, 8'hC3);

        // Reset during write data phase
        bus.start = 1'b1; bus.rw = 1'b0; bus.addr_idx = 5'd5; bus.wdata = 8'h3C;
        @(negedge clk); bus.start = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_rst_wr_n", 8'(bus.wr_n), 8'd0);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_cs_n",   8'(bus.cs_n),   8'd1);
        chk("rst_mid_wr_n",   8'(bus.wr_n),   8'd1);
        chk("rst_mid_ad_oe",  8'(bus.ad_oe),  8'd0);
        chk("rst_mid_ad_out", bus.ad_out,     8'd0);
        chk("rst_mid_rdata",  bus.rdata,      8'd0);
        chk("rst_mid_busy",   8'(bus.busy),   8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        nf = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.final_wr || bus.busy) nf++;
        end
        chk("rst_no_final", 8'(nf), 8'd0);

        // Out-of-range index
        bus.start = 1'b1; bus.addr_idx = 5'd0;
        @(negedge clk); bus.start = 1'b0;
        chk("range_err", 8'(bus.err), 8'(RCHK));
        busy_hi = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.busy || !bus.cs_n || bus.err) busy_hi++;
        end
        chk("range_idle", 8'(busy_hi), 8'd0);

        // 21 back-to-back reads, sequencer advances on final_wr
        seen_addr.delete();
        mon_en = 1'b1;
        pulses = 0;
        bus.rw = 1'b1; bus.addr_idx = 5'd1; bus.start = 1'b1;
        for (int c = 0; c < 21 * (LAT + 4) && pulses < 21; c++) begin
            @(negedge clk);
            bus.ad_in = 8'($urandom);
            if (bus.final_wr) begin
                pulses++;
                if (pulses < 21) bus.addr_idx = 5'(bus.addr_idx + 5'd1);
                else bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        mon_en = 1'b0;
        chk("seq_pulses", 8'(pulses), 8'd21);
        chk("seq_naddr",  8'(seen_addr.size()), 8'd21);
        for (int i = 0; i < seen_addr.size() && i < 21; i++) begin
            want_a = BASE + 8'(i);
            chk("seq_addr", seen_addr[i], want_a);
        end
        repeat (3) @(negedge clk);

        // Randomized traffic with occasional asynchronous reset
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.rw       = 1'($urandom);
            bus.addr_idx = 5'($urandom_range(0, 23));
            bus.wdata    = 8'($urandom);
            bus.ad_in    = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
            end
        end
        bus.start = 1'b0;
        repeat (LAT + 3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/rtc_bus_txn.md
RTC_BUS_TXN -- requirements
Module: rtc_bus_txn

Interface
REQ-001 Parameter T_PHASE, default 4: clk cycles per bus phase, legal range 1..15.
REQ-002 Parameter ADDR_BASE, default 8'h21: RTC register address for addr_idx=1.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request one bus transaction; sampled in IDLE only.
REQ-006 rw  input  1  1=read, 0=write; captured with start.
REQ-007 addr_idx  input  5  sequence code 1..21 from the read/write sequencer; captured with start.
REQ-008 wdata  input  8  write data; captured with start.
REQ-009 ad_in  input  8  multiplexed bus input from the RTC.
REQ-010 ad_out  output  8  multiplexed bus drive value.
REQ-011 ad_oe  output  1  1=block drives the bus.
REQ-012 cs_n, rd_n, wr_n  output  1 each  RTC chip select, read strobe, write strobe; active-low.
REQ-013 a_d  output  1  0=address phase, 1=data phase.
REQ-014 rdata  output  8  last captured read data.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 final_wr  output  1  one-cycle pulse at transaction end; drives the sequencer's Final_WR.
REQ-017 err  output  1  one-cycle range-error pulse; see Configuration.

Function
REQ-018 States: IDLE, ADR_LO, ADR_HI, GAP, DAT_LO, DAT_HI, DONE; all outputs registered.
REQ-019 IDLE: cs_n=rd_n=wr_n=1, ad_oe=0, a_d=0, final_wr=0; start=1 with legal addr_idx latches rw/addr_idx/wdata and moves to ADR_LO.
REQ-020 Address = ADDR_BASE + addr_idx - 1, 8-bit modulo arithmetic.
REQ-021 ADR_LO: cs_n=0, wr_n=0, a_d=0, ad_oe=1, ad_out=address; lasts T_PHASE cycles.
REQ-022 ADR_HI: wr_n=1, cs_n=0, ad_out held; lasts T_PHASE cycles.
REQ-023 GAP: cs_n=1, ad_oe=0, strobes high; lasts T_PHASE cycles.
REQ-024 DAT_LO: cs_n=0, a_d=1; write: wr_n=0, ad_oe=1, ad_out=wdata; read: rd_n=0, ad_oe=0; lasts T_PHASE cycles.
REQ-025 Read: ad_in sampled into rdata on the edge leaving DAT_LO; rdata unchanged otherwise, including across writes.
REQ-026 DAT_HI: strobes high, cs_n=0, a_d=1, write data still driven; lasts T_PHASE cycles.
REQ-027 DONE: one cycle, cs_n=1, ad_oe=0, final_wr=1; next state IDLE unconditionally.
REQ-028 Latency: final_wr high exactly 5*T_PHASE+1 cycles after the edge accepting start.
REQ-029 A phase counter (4 bits) reloads at each state entry; no state lasts longer than specified.
REQ-030 start while busy=1 is ignored, never queued; latched rw/addr_idx/wdata stay stable for the whole transaction.
REQ-031 start held high across DONE starts a new transaction only from IDLE, i.e. at least one IDLE cycle between transactions.
REQ-032 ad_oe and rd_n=0 never true in the same cycle.

Reset
REQ-033 reset asserted, any state including mid-transaction: state=IDLE, cs_n=rd_n=wr_n=1, ad_oe=0, a_d=0, ad_out=0, rdata=0, busy=0, final_wr=0, err=0, counter=0.
REQ-034 An aborted transaction produces no final_wr; after reset release the block waits in IDLE for start.

Configuration
REQ-035 Macro RTC_RANGE_CHECK_EN defined: start in IDLE with addr_idx=0 or >21 stays in IDLE and pulses err for one cycle; no bus activity, no final_wr.
REQ-036 Macro RTC_RANGE_CHECK_EN undefined: err tied 0; out-of-range start silently ignored, stays in IDLE.

Verification (T_PHASE=4, ADDR_BASE=8'h21)
REQ-037 Write addr_idx=1, wdata=8'h5A -> ad_out=8'h21 with wr_n low 4 cycles, then 8'h5A with wr_n low 4 cycles, final_wr pulse at cycle 21.
REQ-038 Read addr_idx=21, ad_in=8'hC3 during DAT_LO -> address 8'h35, rd_n low 4 cycles, ad_oe=0 in data phase, rdata=8'hC3, final_wr at cycle 21.
REQ-039 start re-pulsed at cycles 3 and 10 of a transaction -> ignored, single final_wr, latched fields unchanged.
REQ-040 reset asserted during DAT_LO of a write -> all outputs at reset values immediately, no final_wr.
REQ-041 start with addr_idx=0 -> with RTC_RANGE_CHECK_EN one-cycle err, busy stays 0; without it err=0, busy stays 0.
REQ-042 21 back-to-back reads driven by a sequencer advancing on final_wr -> addresses 8'h21..8'h35 in order, 21 final_wr pulses.
